fft_packetizer: RTL and testbench



---
 rtl/fft_packetizer.sv | 156 +++++++++++++++
 tb/tb_fft_packetizer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_packetizer.sv
// fft_packetizer: buffers FFT bins into fixed-size packets and streams them as 32-bit words with a 2-word header
module fft_packetizer #(
  parameter int FFT_SIZE = 4096,
  parameter int BINS_PER_PKT = 128,
  parameter int FIFO_DEPTH = 1024,
  parameter logic [15:0] MAGIC = 16'hA55A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] in_real,
  input  logic [23:0] in_imag,
  input  logic [$clog2(FFT_SIZE)-1:0] in_index,
  input  logic        in_valid,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [15:0] m_len,
  output logic [15:0] drop_count,
  output logic        seq_error,
  output logic        overflow
);
  localparam int IW = $clog2(FFT_SIZE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BINS_PER_PKT);
  localparam int ND = FIFO_DEPTH / BINS_PER_PKT;
  localparam int DW = (ND > 1) ? $clog2(ND) : 1;
  localparam int PW = (CW > 1) ? CW - 1 : 1;
  typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAY} state_t;
  state_t state, state_nx;
  logic [47:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ;
  logic w_act, w_drop;
  logic [CW-1:0] w_cnt;
  logic [IW-1:0] w_prev, w_start;
  logic [IW-1:0] d_mem [2**DW];
  logic [DW-1:0] d_wr, d_rd;
  logic [DW:0] d_cnt;
  logic [1:0] phase;
  logic [PW-1:0] pcnt;
  logic [15:0] seq;
  logic [47:0] b0, b1;
  logic is_start, idle_w, admit, drop, wr_en, w_done, d_push, fire, pay_end, pkt_end;
  assign is_start = in_valid && in_index[CW-1:0] == '0;
  assign idle_w = !w_act && !w_drop;
  assign admit = idle_w && is_start && enable && occ <= (AW+1)'(FIFO_DEPTH - BINS_PER_PKT);
  assign drop = idle_w && is_start && enable && !admit;
  assign wr_en = admit || (in_valid && w_act);
  assign w_done = w_cnt == CW'(BINS_PER_PKT - 1);
  assign d_push = in_valid && w_act && w_done;
  assign m_valid = state != IDLE;
  assign fire = m_valid && m_ready;
  assign pay_end = fire && state == PAY && phase == 2'd2;
  assign pkt_end = pay_end && pcnt == PW'(BINS_PER_PKT / 2 - 1);
  assign b0 = mem[rd_ptr];
  assign b1 = mem[rd_ptr + AW'(1)];
  assign m_len = 16'(8 + 6 * BINS_PER_PKT);
  // Storage arrays: bin buffer and descriptor queue, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {in_real, in_imag};
    if (d_push) d_mem[d_wr] <= w_start;
  end
  // Writer: admit or drop whole packets at each packet-start bin, track sequencing and drops
  always_ff @(posedge clk) begin
    if (rst) begin
      w_act <= 1'b0;
      w_drop <= 1'b0;
      w_cnt <= '0;
      w_prev <= '0;
      w_start <= '0;
      wr_ptr <= '0;
      drop_count <= '0;
      overflow <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      if (admit) begin
        w_act <= 1'b1;
        w_cnt <= CW'(1);
        w_start <= in_index;
      end else if (drop) begin
        w_drop <= 1'b1;
        w_cnt <= CW'(1);
        overflow <= 1'b1;
        drop_count <= drop_count + 16'(drop_count != 16'hFFFF);
      end else if (in_valid && (w_act || w_drop)) begin
        w_cnt <= w_cnt + CW'(1);
        if (w_done) begin
          w_act <= 1'b0;
          w_drop <= 1'b0;
        end
        if (w_act && in_index != w_prev + 1'b1) seq_error <= 1'b1;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        w_prev <= in_index;
      end
    end
  end
  // Occupancy and pointers: bins enter one at a time, leave two per completed payload triple
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      rd_ptr <= '0;
      d_wr <= '0;
      d_rd <= '0;
      d_cnt <= '0;
    end else begin
      occ <= occ + (AW+1)'(wr_en) - (pay_end ? (AW+1)'(2) : '0);
      if (pay_end) rd_ptr <= rd_ptr + AW'(2);
      if (d_push) d_wr <= d_wr + DW'(1);
      if (pkt_end) d_rd <= d_rd + DW'(1);
      d_cnt <= d_cnt + (DW+1)'(d_push) - (DW+1)'(pkt_end);
    end
  end
  // Reader state register with payload phase, pair counter and packet sequence number
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      pcnt <= '0;
      seq <= '0;
    end else begin
      state <= state_nx;
      if (pay_end) begin
        phase <= '0;
        pcnt <= pkt_end ? '0 : pcnt + PW'(1);
      end else if (fire && state == PAY) phase <= phase + 2'd1;
      if (pkt_end) seq <= seq + 16'd1;
    end
  end
  // Reader next state and output word; outputs depend only on held state so they stay stable under stall
  always_comb begin
    state_nx = state;
    m_data = '0;
    m_last = 1'b0;
    case (state)
      IDLE: state_nx = (d_cnt != '0) ? HDR0 : IDLE;
      HDR0: begin
        m_data = {MAGIC, seq};
        state_nx = m_ready ? HDR1 : HDR0;
      end
      HDR1: begin
        m_data = {4'h0, 12'(d_mem[d_rd]), 16'(BINS_PER_PKT)};
        state_nx = m_ready ? PAY : HDR1;
      end
      PAY: begin
        m_data = (phase == 2'd0) ? b0[47:16] : (phase == 2'd1) ? {b0[15:0], b1[47:32]} : b1[31:0];
        m_last = phase == 2'd2 && pcnt == PW'(BINS_PER_PKT / 2 - 1);
        if (m_last && m_ready) state_nx = (d_cnt > (DW+1)'(1) || d_push) ? HDR0 : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fft_packetizer.sv
// tb_fft_packetizer: directed checks of packet framing, admission/drop, backpressure and reset
module tb_fft_packetizer;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, in_valid = 1'b0, m_ready = 1'b0;
  logic [23:0] in_real = '0, in_imag = '0;
  logic [11:0] in_index = '0;
  logic [31:0] m_data;
  logic m_valid, m_last, seq_error, overflow;
  logic [15:0] m_len, drop_count;
  int n_vec = 0, n_err = 0;
  logic [23:0] log_r[$], log_i[$];
  logic [31:0] exp_d[$], got_d[$];
  logic exp_l[$], got_l[$];
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;

  fft_packetizer #(.FFT_SIZE(4096), .BINS_PER_PKT(8), .FIFO_DEPTH(16), .MAGIC(16'hA55A)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_real(in_real), .in_imag(in_imag),
    .in_index(in_index), .in_valid(in_valid), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .m_len(m_len), .drop_count(drop_count),
    .seq_error(seq_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Collect handshaken words and verify outputs hold while stalled
  always @(negedge clk) begin
    if (!rst && prev_stall) begin
      chk("stall_valid", 32'(m_valid), 1);
      chk("stall_data", m_data, prev_data);
      chk("stall_last", 32'(m_last), 32'(prev_last));
    end
    if (!rst && m_valid && m_ready) begin
      got_d.push_back(m_data);
      got_l.push_back(m_last);
    end
    prev_stall = !rst && m_valid && !m_ready;
    prev_data = m_data;
    prev_last = m_last;
  end

  function automatic logic [23:0] vr(input logic [11:0] idx);
    return {4'hC, idx, 8'h3C};
  endfunction

  function automatic logic [23:0] vi(input logic [11:0] idx);
    return {8'h96, idx, 4'h7};
  endfunction

  task automatic send(input logic [11:0] idx, input logic [23:0] r, input logic [23:0] i);
    in_index = idx;
    in_real = r;
    in_imag = i;
    in_valid = 1'b1;
    log_r.push_back(r);
    log_i.push_back(i);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int a, input int b);
    for (int k = a; k <= b; k++) send(12'(k), vr(12'(k)), vi(12'(k)));
  endtask

  task automatic send_t1_data();
    send(12'd0, 24'h123456, 24'hABCDEF);
    send(12'd1, 24'h000001, 24'hFFFFFE);
    send_range(2, 7);
  endtask

  task automatic add_pkt(input logic [15:0] seq, input logic [11:0] start, input int slot);
    logic [23:0] r0, i0, r1, i1;
    exp_d.push_back({16'hA55A, seq});
    exp_l.push_back(1'b0);
    exp_d.push_back({4'h0, start, 16'd8});
    exp_l.push_back(1'b0);
    for (int p = 0; p < 4; p++) begin
      r0 = log_r[slot + 2*p];
      i0 = log_i[slot + 2*p];
      r1 = log_r[slot + 2*p + 1];
      i1 = log_i[slot + 2*p + 1];
      exp_d.push_back({r0, i0[23:16]});
      exp_l.push_back(1'b0);
      exp_d.push_back({i0[15:0], r1[23:8]});
      exp_l.push_back(1'b0);
      exp_d.push_back({r1[7:0], i1});
      exp_l.push_back(p == 3);
    end
  endtask

  task automatic drain(input string tag);
    int t = 0, w = 0;
    while (got_d.size() < exp_d.size() && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, "_count"}, 32'(got_d.size()), 32'(exp_d.size()));
    while (exp_d.size() > 0 && got_d.size() > 0) begin
      chk($sformatf("%s_w%0d", tag, w), got_d.pop_front(), exp_d.pop_front());
      chk($sformatf("%s_last%0d", tag, w), 32'(got_l.pop_front()), 32'(exp_l.pop_front()));
      w++;
    end
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_extra"}, 32'(got_d.size()), 0);
    chk({tag, "_idle"}, 32'(m_valid), 0);
    got_d.delete();
    got_l.delete();
    exp_d.delete();
    exp_l.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_d.delete();
    got_l.delete();
    exp_d.delete();
    exp_l.delete();
    log_r.delete();
    log_i.delete();
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_data", m_data, 0);
    chk("rst_drops", 32'(drop_count), 0);
    chk("rst_seqerr", 32'(seq_error), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("m_len", 32'(m_len), 56);
    // basic packet with header, packing and latency
    m_ready = 1'b1;
    send_t1_data();
    k = 0;
    while (!m_valid && k < 3) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t1_latency", 32'(m_valid), 1);
    repeat (20) @(posedge clk);
    #1;
    chk("t1_hdr0", got_d[0], 32'hA55A0000);
    chk("t1_hdr1", got_d[1], 32'h00000008);
    chk("t1_p0", got_d[2], 32'h123456AB);
    chk("t1_p1", got_d[3], 32'hCDEF0000);
    chk("t1_p2", got_d[4], 32'h01FFFFFE);
    chk("t1_lastflag", 32'(got_l[13]), 1);
    add_pkt(16'd0, 12'd0, 0);
    drain("t1");
    chk("t1_seqerr", 32'(seq_error), 0);
    // same packet with random backpressure
    do_reset();
    fork
      send_t1_data();
      repeat (60) begin
        m_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    join
    m_ready = 1'b1;
    add_pkt(16'd0, 12'd0, 0);
    drain("t3");
    // buffer full: two admitted, four dropped
    do_reset();
    m_ready = 1'b0;
    send_range(0, 47);
    chk("t2_drops", 32'(drop_count), 4);
    chk("t2_ovf", 32'(overflow), 1);
    m_ready = 1'b1;
    add_pkt(16'd0, 12'd0, 0);
    add_pkt(16'd1, 12'd8, 8);
    drain("t2");
    // mid-packet start is ignored until next boundary
    do_reset();
    send_range(3, 15);
    add_pkt(16'd0, 12'd8, 5);
    drain("t4");
    chk("t4_seqerr", 32'(seq_error), 0);
    chk("t4_drops", 32'(drop_count), 0);
    // index gap inside an admitted packet
    do_reset();
    send_range(0, 2);
    send_range(4, 8);
    chk("t5_seqerr", 32'(seq_error), 1);
    add_pkt(16'd0, 12'd0, 0);
    drain("t5");
    // enable low: nothing admitted, nothing counted as dropped
    do_reset();
    enable = 1'b0;
    send_range(0, 7);
    drain("t7");
    chk("t7_drops", 32'(drop_count), 0);
    chk("t7_ovf", 32'(overflow), 0);
    enable = 1'b1;
    // reset mid-payload
    do_reset();
    m_ready = 1'b0;
    send_range(0, 23);
    chk("t6_drops_pre", 32'(drop_count), 1);
    m_ready = 1'b1;
    k = 0;
    while (got_d.size() < 5 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t6_midpay", 32'(got_d.size() >= 5), 1);
    do_reset();
    chk("t6_valid", 32'(m_valid), 0);
    chk("t6_drops", 32'(drop_count), 0);
    chk("t6_ovf", 32'(overflow), 0);
    send_range(0, 7);
    add_pkt(16'd0, 12'd0, 0);
    drain("t6");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
